// File: rtl/vid_osd_text_engine.sv
// vid_osd_text_engine
// Renders a COLS x ROWS character window at a programmable origin with per-axis
// pixel scaling and a blinking cursor. Text and font bytes are fetched through two
// read ports with fixed latency MEM_LAT. The result is registered L = 2*MEM_LAT+2
// pixel steps after the raster sample, and the timing inputs are delayed to match.
// The engine advances only on a pixel step (i_pc_ena == 0); i_reset acts on any clock.
//
// Ports:
//   i_clk, i_reset                  pixel clock, synchronous active-high reset
//   i_pc_ena                        pixel step strobe (step when zero)
//   i_hde/vde/hs/vs_in              raw video timing
//   i_win_x/y, i_scale_x/y          window origin and magnification minus one
//   i_cursor_ena/col/row            cursor control
//   o_text_addr / i_text_data       text RAM port (bit7 of data = attribute)
//   o_font_addr / i_font_data       font RAM port (bit7 of data = leftmost pixel)
//   o_osd_ena_out, o_osd_image      {attr, pixel ^ cursor, cursor} and window flag
//   o_hde/vde/hs/vs_out             timing delayed by L pixel steps
module vid_osd_text_engine #(
    parameter int unsigned COLS       = 32,
    parameter int unsigned ROWS       = 16,
    parameter int unsigned FONT_H     = 8,
    parameter int unsigned MEM_LAT    = 2,
    parameter logic [19:0] TEXT_BASE  = 20'h01000,
    parameter logic [19:0] FONT_BASE  = 20'h00800,
    parameter int unsigned BLINK_LOG2 = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_pc_ena,
    input  logic        i_hde_in,
    input  logic        i_vde_in,
    input  logic        i_hs_in,
    input  logic        i_vs_in,
    input  logic [11:0] i_win_x,
    input  logic [11:0] i_win_y,
    input  logic [1:0]  i_scale_x,
    input  logic [1:0]  i_scale_y,
    input  logic        i_cursor_ena,
    input  logic [6:0]  i_cursor_col,
    input  logic [5:0]  i_cursor_row,
    output logic [19:0] o_text_addr,
    input  logic [7:0]  i_text_data,
    output logic [19:0] o_font_addr,
    input  logic [7:0]  i_font_data,
    output logic        o_osd_ena_out,
    output logic [2:0]  o_osd_image,
    output logic        o_hde_out,
    output logic        o_vde_out,
    output logic        o_hs_out,
    output logic        o_vs_out
);
    localparam int unsigned CXW   = $clog2(COLS);
    localparam int unsigned CYW   = $clog2(ROWS);
    localparam int unsigned GYW   = $clog2(FONT_H);
    localparam int unsigned L     = 2 * MEM_LAT + 2;
    localparam int unsigned SBD   = 2 * MEM_LAT + 1;
    localparam logic [12:0] WIN_W = 13'(COLS * 8);
    localparam logic [12:0] WIN_H = 13'(ROWS * FONT_H);

    // Per-pixel side band travelling alongside the memory fetches.
    typedef struct packed {
        logic           act;
        logic           cur;
        logic [2:0]     gx;
        logic [GYW-1:0] gy;
    } sb_t;

    logic            r_hde_prev, r_vs_prev, r_y_started;
    logic [11:0]     r_ras_x, r_ras_y;
    logic [11:0]     r_win_x, r_win_y;
    logic [1:0]      r_scale_x, r_scale_y;
    logic            r_cur_ena;
    logic [6:0]      r_cur_col;
    logic [5:0]      r_cur_row;
    logic [BLINK_LOG2-1:0] r_frame;
    logic [1:0]      r_sub_x, r_sub_y;
    logic [2:0]      r_gx;
    logic [GYW-1:0]  r_gy;
    logic [CXW-1:0]  r_cx;
    logic [CYW-1:0]  r_cy;
    logic [19:0]     r_text_addr, r_font_addr;
    sb_t             r_sb   [SBD];
    logic            r_attr [MEM_LAT+1];
    logic            r_pix;
    logic [3:0]      r_tim  [L];
    logic            r_osd_ena;
    logic [2:0]      r_osd_img;

    logic            w_step, w_hde_rise, w_vs_rise, w_y_started;
    logic [11:0]     w_x, w_y;
    logic [12:0]     w_x_end, w_y_end;
    logic            w_in_x, w_in_y, w_act, w_cur;
    logic [1:0]      w_sub_x, w_sub_y;
    logic [2:0]      w_gx;
    logic [GYW-1:0]  w_gy;
    logic [CXW-1:0]  w_cx;
    logic [CYW-1:0]  w_cy;
    sb_t             w_sb_new;

    assign w_step     = (i_pc_ena == 4'd0);
    assign w_hde_rise = i_hde_in & ~r_hde_prev;
    assign w_vs_rise  = i_vs_in & ~r_vs_prev;

    always_comb begin
        // Raster position of the current sample.
        w_x = w_hde_rise ? 12'd0 : ((r_ras_x == 12'hFFF) ? r_ras_x : r_ras_x + 12'd1);
        w_y         = r_ras_y;
        w_y_started = r_y_started;
        if (!i_vde_in) begin
            w_y         = 12'd0;
            w_y_started = 1'b0;
        end else if (w_hde_rise) begin
            // The first line of the frame is line 0; every later line rise counts up.
            w_y         = !r_y_started ? 12'd0 : ((r_ras_y == 12'hFFF) ? r_ras_y : r_ras_y + 12'd1);
            w_y_started = 1'b1;
        end

        w_x_end = {1'b0, r_win_x} + WIN_W * (13'(r_scale_x) + 13'd1);
        w_y_end = {1'b0, r_win_y} + WIN_H * (13'(r_scale_y) + 13'd1);
        w_in_x  = ({1'b0, w_x} >= {1'b0, r_win_x}) && ({1'b0, w_x} < w_x_end);
        w_in_y  = ({1'b0, w_y} >= {1'b0, r_win_y}) && ({1'b0, w_y} < w_y_end);
        // Gating by hde/vde clips a window that runs past the active area.
        w_act   = i_hde_in & i_vde_in & w_in_x & w_in_y;

        w_sub_x = r_sub_x;
        w_gx    = r_gx;
        w_cx    = r_cx;
        if (w_x == r_win_x) begin
            w_sub_x = 2'd0;
            w_gx    = 3'd0;
            w_cx    = '0;
        end else if (w_act) begin
            if (w_sub_x == r_scale_x) begin
                w_sub_x = 2'd0;
                if (w_gx == 3'd7) begin
                    w_gx = 3'd0;
                    w_cx = w_cx + CXW'(1);
                end else begin
                    w_gx = w_gx + 3'd1;
                end
            end else begin
                w_sub_x = w_sub_x + 2'd1;
            end
        end

        w_sub_y = r_sub_y;
        w_gy    = r_gy;
        w_cy    = r_cy;
        if (w_hde_rise) begin
            if (w_y == r_win_y) begin
                w_sub_y = 2'd0;
                w_gy    = '0;
                w_cy    = '0;
            end else if (w_in_y && i_vde_in) begin
                if (w_sub_y == r_scale_y) begin
                    w_sub_y = 2'd0;
                    if (w_gy == GYW'(FONT_H - 1)) begin
                        w_gy = '0;
                        w_cy = w_cy + CYW'(1);
                    end else begin
                        w_gy = w_gy + GYW'(1);
                    end
                end else begin
                    w_sub_y = w_sub_y + 2'd1;
                end
            end
        end

        w_cur = r_cur_ena & ~r_frame[BLINK_LOG2-1] &
                (7'(w_cx) == r_cur_col) & (6'(w_cy) == r_cur_row);
        w_sb_new.act = w_act;
        w_sb_new.cur = w_cur;
        w_sb_new.gx  = w_gx;
        w_sb_new.gy  = w_gy;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hde_prev  <= 1'b0;
            r_vs_prev   <= 1'b0;
            r_y_started <= 1'b0;
            r_ras_x     <= '0;
            r_ras_y     <= '0;
            r_win_x     <= '0;
            r_win_y     <= '0;
            r_scale_x   <= '0;
            r_scale_y   <= '0;
            r_cur_ena   <= 1'b0;
            r_cur_col   <= '0;
            r_cur_row   <= '0;
            r_frame     <= '0;
            r_sub_x     <= '0;
            r_sub_y     <= '0;
            r_gx        <= '0;
            r_gy        <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_text_addr <= '0;
            r_font_addr <= '0;
            r_pix       <= 1'b0;
            r_osd_ena   <= 1'b0;
            r_osd_img   <= '0;
            for (int i = 0; i < SBD; i++) r_sb[i] <= '0;
            for (int i = 0; i <= MEM_LAT; i++) r_attr[i] <= 1'b0;
            for (int i = 0; i < L; i++) r_tim[i] <= '0;
        end else if (w_step) begin
            r_hde_prev  <= i_hde_in;
            r_vs_prev   <= i_vs_in;
            r_y_started <= w_y_started;
            r_ras_x     <= w_x;
            r_ras_y     <= w_y;
            if (w_vs_rise) begin
                r_win_x   <= i_win_x;
                r_win_y   <= i_win_y;
                r_scale_x <= i_scale_x;
                r_scale_y <= i_scale_y;
                r_cur_ena <= i_cursor_ena;
                r_cur_col <= i_cursor_col;
                r_cur_row <= i_cursor_row;
                r_frame   <= r_frame + BLINK_LOG2'(1);
            end
            r_sub_x <= w_sub_x;
            r_sub_y <= w_sub_y;
            r_gx    <= w_gx;
            r_gy    <= w_gy;
            r_cx    <= w_cx;
            r_cy    <= w_cy;
            // Power-of-two geometry turns the address products into concatenations.
            r_text_addr <= TEXT_BASE + 20'({w_cy, w_cx});
            r_font_addr <= FONT_BASE + 20'({i_text_data[6:0], r_sb[MEM_LAT-1].gy});
            r_attr[0]   <= i_text_data[7];
            for (int i = 1; i <= MEM_LAT; i++) r_attr[i] <= r_attr[i-1];
            r_sb[0] <= w_sb_new;
            for (int i = 1; i < SBD; i++) r_sb[i] <= r_sb[i-1];
            r_pix <= i_font_data[~r_sb[2*MEM_LAT-1].gx];
            r_osd_ena <= r_sb[2*MEM_LAT].act;
            r_osd_img <= r_sb[2*MEM_LAT].act ?
                         {r_attr[MEM_LAT], r_pix ^ r_sb[2*MEM_LAT].cur, r_sb[2*MEM_LAT].cur} :
                         3'b000;
            r_tim[0] <= {i_hde_in, i_vde_in, i_hs_in, i_vs_in};
            for (int i = 1; i < L; i++) r_tim[i] <= r_tim[i-1];
        end
    end

    assign o_text_addr   = r_text_addr;
    assign o_font_addr   = r_font_addr;
    assign o_osd_ena_out = r_osd_ena;
    assign o_osd_image   = r_osd_img;
    assign o_hde_out     = r_tim[L-1][3];
    assign o_vde_out     = r_tim[L-1][2];
    assign o_hs_out      = r_tim[L-1][1];
    assign o_vs_out      = r_tim[L-1][0];
endmodule
